// File: rtl/cp0_int_unit_pkg.sv
// Shared encodings for the CP0 / interrupt unit: controller op codes,
// CP0 register indices, SR/CAUSE bit positions and FSM states.
package cp0_int_unit_pkg;

   typedef enum logic [1:0] {
      EXE_CP_NONE  = 2'b00,
      EXE_CP_STORE = 2'b01,
      EXE_CP0_ERET = 2'b10,
      EXE_CP_RSVD  = 2'b11
   } cp0_oper_e;

   localparam logic [4:0] CP0_REG_SR    = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
   localparam logic [4:0] CP0_REG_EPC   = 5'd14;
   localparam logic [4:0] CP0_REG_EHBR  = 5'd25;

   localparam int SR_IE_BIT      = 0;
   localparam int CAUSE_CODE_LSB = 2;
   localparam int CAUSE_CODE_MSB = 6;
   localparam int CAUSE_CODE_W   = CAUSE_CODE_MSB - CAUSE_CODE_LSB + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTER = 2'd1,
      ST_RET   = 2'd2,
      ST_HOLD  = 2'd3
   } cp0_state_e;

endpackage

// File: rtl/cp0_int_unit_int_sync.sv
// Multi-flop synchroniser for the asynchronous interrupt request, followed
// by a rising-edge detector that yields a one-cycle ir_edge.
module int_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ir_in,
   output logic ir_edge
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ir_prev;

   // Free-running: the pipeline enable does not stall the synchroniser.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q  <= '0;
         ir_prev <= 1'b0;
      end else begin
         sync_q[0] <= ir_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         ir_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign ir_edge = sync_q[SYNC_STAGES-1] & ~ir_prev;

endmodule

// File: rtl/cp0_int_unit.sv
// Coprocessor-0 register file and interrupt entry / ERET sequencer that
// issues a registered one-cycle redirect back to the pipeline.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for ERET or a pending, enabled interrupt
// ENTER | redirect pulse to EHBR is on jump_en/jump_addr this cycle
// RET   | redirect pulse to EPC is on jump_en/jump_addr this cycle
// HOLD  | HOLD_CYC down-count after a redirect; no entry, ERET ignored
module cp0_int_unit
   import cp0_int_unit_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYC    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        oper,
   input  logic [4:0]        addr_r,
   output logic [DATA_W-1:0] data_r,
   input  logic [4:0]        addr_w,
   input  logic [DATA_W-1:0] data_w,
   input  logic [DATA_W-1:0] ret_addr,
   input  logic              id_valid,
   input  logic              ir_in,
   output logic              jump_en,
   output logic [DATA_W-1:0] jump_addr
);

   localparam int HOLD_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

   cp0_state_e              state, state_nxt;
   logic [HOLD_W-1:0]       hold_cnt, hold_nxt;
   logic                    sr_ie;
   logic [CAUSE_CODE_W-1:0] cause_code;
   logic [DATA_W-1:0]       epc;
   logic [DATA_W-1:0]       ehbr;
   logic                    pend;
   logic                    ir_edge;
   logic                    take_int;
   logic                    take_ret;
   logic                    is_mtc0;
   logic                    is_eret;

   int_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk     (clk),
      .rst     (rst),
      .ir_in   (ir_in),
      .ir_edge (ir_edge)
   );

   assign is_mtc0 = (oper == EXE_CP_STORE);
   assign is_eret = (oper == EXE_CP0_ERET);

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      take_int  = 1'b0;
      take_ret  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (is_eret) begin
               state_nxt = ST_RET;
               take_ret  = 1'b1;
            end else if (pend && sr_ie && id_valid && (hold_cnt == '0)) begin
               state_nxt = ST_ENTER;
               take_int  = 1'b1;
            end
         end
         ST_ENTER, ST_RET: begin
            state_nxt = ST_HOLD;
            hold_nxt  = HOLD_W'(HOLD_CYC);
         end
         ST_HOLD: begin
            // Terminal count: leave HOLD on the step that brings the counter to 0.
            if (hold_cnt <= HOLD_W'(1)) begin
               state_nxt = ST_IDLE;
               hold_nxt  = '0;
            end else begin
               hold_nxt = hold_cnt - HOLD_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         hold_cnt   <= '0;
         sr_ie      <= 1'b0;
         cause_code <= '0;
         epc        <= '0;
         ehbr       <= '0;
         pend       <= 1'b0;
         jump_en    <= 1'b0;
         jump_addr  <= '0;
      end else if (en) begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;

         if (ir_edge) begin
            pend <= 1'b1;
         end

         if (is_mtc0) begin
            case (addr_w)
               CP0_REG_SR:   sr_ie <= data_w[SR_IE_BIT];
               CP0_REG_EPC:  epc   <= data_w;
               CP0_REG_EHBR: ehbr  <= data_w;
               default: ;
            endcase
         end

         // Entry side effects win over a same-cycle MTC0 and a same-cycle edge.
         if (take_int) begin
            epc        <= ret_addr;
            sr_ie      <= 1'b0;
            cause_code <= '0;
            pend       <= 1'b0;
         end

         if (take_ret) begin
            sr_ie <= 1'b1;
         end

         jump_en <= take_int | take_ret;
         if (take_int) begin
            jump_addr <= ehbr;
         end else if (take_ret) begin
            jump_addr <= epc;
         end else begin
            jump_addr <= '0;
         end
      end else begin
         jump_en   <= 1'b0;
         jump_addr <= '0;
      end
   end

   always_comb begin
      data_r = '0;
      case (addr_r)
         CP0_REG_SR: data_r[SR_IE_BIT] = sr_ie;
         CP0_REG_CAUSE: begin
            data_r[DATA_W-1]                       = pend;
            data_r[CAUSE_CODE_MSB:CAUSE_CODE_LSB] = cause_code;
         end
         CP0_REG_EPC:  data_r = epc;
         CP0_REG_EHBR: data_r = ehbr;
         default:      data_r = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_int_unit.sv
// Scoreboard bench for cp0_int_unit: stimulus queues expected redirects and
// register reads, a negedge monitor pops and compares them.
module tb_cp0_int_unit;

   logic        clk;
   logic        rst;
   logic        en;
   logic [1:0]  oper;
   logic [4:0]  addr_r;
   logic [31:0] data_r;
   logic [4:0]  addr_w;
   logic [31:0] data_w;
   logic [31:0] ret_addr;
   logic        id_valid;
   logic        ir_in;
   logic        jump_en;
   logic [31:0] jump_addr;

   typedef struct {
      logic [31:0] addr;
      int          lo;
      int          hi;
   } jexp_t;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] val;
   } rexp_t;

   jexp_t jq[$];
   rexp_t rq[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   logic  rd_req = 1'b0;
   logic  jump_prev = 1'b0;

   cp0_int_unit #(
      .DATA_W      (32),
      .SYNC_STAGES (2),
      .HOLD_CYC    (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .oper      (oper),
      .addr_r    (addr_r),
      .data_r    (data_r),
      .addr_w    (addr_w),
      .data_w    (data_w),
      .ret_addr  (ret_addr),
      .id_valid  (id_valid),
      .ir_in     (ir_in),
      .jump_en   (jump_en),
      .jump_addr (jump_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      jexp_t je;
      rexp_t re;
      if (jump_en) begin
         checks++;
         if (jump_prev) begin
            errors++;
            $display("FAIL pulse_width: jump_en high on consecutive cycles at cycle %0d, required one-cycle pulse", cyc);
         end
         checks++;
         if (jq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_jump: jump_addr=%h at cycle %0d, required no jump", jump_addr, cyc);
         end else begin
            je = jq.pop_front();
            if (jump_addr !== je.addr) begin
               errors++;
               $display("FAIL jump_addr: got %h, required %h (cycle %0d)", jump_addr, je.addr, cyc);
            end
            if (je.lo >= 0) begin
               checks++;
               if (cyc < je.lo || cyc > je.hi) begin
                  errors++;
                  $display("FAIL jump_time: pulse at cycle %0d, required %0d..%0d", cyc, je.lo, je.hi);
               end
            end
         end
      end else begin
         checks++;
         if (jump_addr !== 32'h0) begin
            errors++;
            $display("FAIL idle_addr: jump_addr=%h while jump_en=0, required 0", jump_addr);
         end
      end
      jump_prev = jump_en;

      if (rd_req) begin
         checks++;
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL read_queue: read strobe with no expected value");
         end else begin
            re = rq.pop_front();
            if (data_r !== re.val) begin
               errors++;
               $display("FAIL mfc0_%0d: data_r=%h, required %h", re.idx, data_r, re.val);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      oper   = 2'b01;
      addr_w = a;
      data_w = d;
      step(1);
      oper   = 2'b00;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] v);
      rexp_t re;
      re.idx = a;
      re.val = v;
      rq.push_back(re);
      addr_r = a;
      rd_req = 1'b1;
      step(1);
      rd_req = 1'b0;
   endtask

   task automatic expect_jump(input logic [31:0] a, input int lo, input int hi);
      jexp_t je;
      je.addr = a;
      je.lo   = lo;
      je.hi   = hi;
      jq.push_back(je);
   endtask

   task automatic wait_jumps(input string tag, input int budget);
      int n;
      n = 0;
      while (jq.size() != 0 && n < budget) begin
         step(1);
         n++;
      end
      checks++;
      if (jq.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d redirects outstanding, required 0", tag, jq.size());
         jq.delete();
      end
   endtask

   task automatic ir_pulse(input int len);
      ir_in = 1'b1;
      step(len);
      ir_in = 1'b0;
   endtask

   initial begin
      int  c0;
      bit  found;
      rst = 1'b0; en = 1'b1; oper = 2'b00; addr_r = 5'd0; addr_w = 5'd0;
      data_w = 32'h0; ret_addr = 32'h0; id_valid = 1'b1; ir_in = 1'b0;
      step(3);
      rst = 1'b1;
      rd(5'd12, 32'h0);
      rd(5'd13, 32'h0);
      rd(5'd14, 32'h0);
      rd(5'd25, 32'h0);

      // Register file, ignored writes, en freeze
      mtc0(5'd25, 32'h0000_1000);
      mtc0(5'd12, 32'hFFFF_FFFF);
      mtc0(5'd13, 32'hFFFF_FFFF);
      mtc0(5'd3,  32'h1234_5678);
      en = 1'b0;
      mtc0(5'd14, 32'hDEAD_BEEF);
      en = 1'b1;
      rd(5'd25, 32'h0000_1000);
      rd(5'd12, 32'h1);
      rd(5'd13, 32'h0);
      rd(5'd3,  32'h0);
      rd(5'd14, 32'h0);

      // Interrupt entry
      ret_addr = 32'h40;
      expect_jump(32'h1000, cyc + 3, cyc + 4);
      ir_pulse(5);
      wait_jumps("entry", 10);
      rd(5'd14, 32'h40);
      rd(5'd12, 32'h0);
      rd(5'd13, 32'h0);

      // ERET
      step(5);
      oper = 2'b10;
      expect_jump(32'h40, cyc + 1, cyc + 1);
      step(1);
      oper = 2'b00;
      wait_jumps("eret", 5);
      rd(5'd12, 32'h1);

      // Edge with IE=0 stays pending; enabling IE takes it
      step(5);
      mtc0(5'd12, 32'h0);
      ret_addr = 32'h80;
      ir_pulse(5);
      step(3);
      rd(5'd13, 32'h8000_0000);
      c0 = cyc;
      expect_jump(32'h1000, c0 + 1, c0 + 2);
      mtc0(5'd12, 32'h1);
      wait_jumps("late_enable", 6);
      rd(5'd14, 32'h80);
      rd(5'd12, 32'h0);
      rd(5'd13, 32'h0);

      // ERET and entry condition together
      step(5);
      id_valid = 1'b0;
      mtc0(5'd12, 32'h1);
      ret_addr = 32'hC0;
      ir_pulse(5);
      step(3);
      rd(5'd13, 32'h8000_0000);
      c0 = cyc;
      expect_jump(32'h80, c0 + 1, c0 + 1);
      expect_jump(32'h1000, c0 + 4, c0 + 5);
      id_valid = 1'b1;
      oper = 2'b10;
      step(1);
      oper = 2'b00;
      wait_jumps("eret_then_int", 10);
      rd(5'd14, 32'hC0);
      rd(5'd12, 32'h0);

      // Reset during ENTER
      step(5);
      mtc0(5'd12, 32'h1);
      ret_addr = 32'h100;
      expect_jump(32'h1000, -1, -1);
      ir_in = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         step(1);
         if (jump_en) found = 1'b1;
      end
      rst = 1'b0;
      ir_in = 1'b0;
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reset_enter_timeout: no ENTER pulse seen, required one");
      end
      step(1);
      rst = 1'b1;
      wait_jumps("reset_enter", 2);
      rd(5'd12, 32'h0);
      rd(5'd14, 32'h0);
      rd(5'd13, 32'h0);
      rd(5'd25, 32'h0);
      ir_pulse(5);
      step(3);
      rd(5'd13, 32'h8000_0000);
      step(6);

      checks++;
      if (rq.size() != 0) begin
         errors++;
         $display("FAIL read_leftover: %0d reads unchecked, required 0", rq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

endmodule

// File: doc/cp0_int_unit.md
Name: cp0_int_unit

Overview:
- Coprocessor-0 and interrupt unit for the 5-stage MIPS pipeline.
- Sits downstream of the ID-stage controller: consumes its CP0 operation code (NONE/MTC0/ERET) and the MFC0/MTC0 register traffic.
- Produces the redirect request `jump_en`/`jump_addr` back to the controller and PC logic.
- Holds STATUS, CAUSE, EPC and the handler base register, and sequences external interrupt entry and ERET return.

Parameters:
- DATA_W, 32, register and address width.
- SYNC_STAGES, 2, number of synchroniser flops on `ir_in`.
- HOLD_CYC, 2, cycles after a redirect during which no new interrupt entry is taken.

Ports:
- clk  in  1  main clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 on a rising clk edge resets the block.
- en  in  1  pipeline enable; 0 freezes all registers except the synchroniser.
- oper  in  2  CP0 operation from the controller: 00 NONE, 01 STORE (MTC0), 10 ERET, 11 reserved (treated as NONE).
- addr_r  in  5  MFC0 source register number.
- data_r  out  32  MFC0 read data; combinational from addr_r.
- addr_w  in  5  MTC0 destination register number.
- data_w  in  32  MTC0 write data.
- ret_addr  in  32  PC of the instruction currently in ID; saved to EPC on interrupt entry.
- id_valid  in  1  ID holds a valid, non-bubble instruction.
- ir_in  in  1  asynchronous external interrupt request, level.
- jump_en  out  1  one-cycle redirect pulse.
- jump_addr  out  32  redirect target, valid while jump_en=1.

Behaviour:
- Register map (5-bit index):
  - 12 SR: bit0 IE, other bits read 0.
  - 13 CAUSE: bit31 PEND read-only mirror, bits[6:2] code (0 = interrupt), other bits 0.
  - 14 EPC: full 32 bits.
  - 25 EHBR: handler base, full 32 bits.
  - Any other index reads 0; writes to it are ignored.
- Reset (rst=0):
  - SR, CAUSE, EPC, EHBR, jump_en, jump_addr = 0.
  - pend = 0; hold counter = 0; state = IDLE; synchroniser flops = 0.
- Synchroniser and edge detect:
  - `ir_in` passes through SYNC_STAGES flops; a 0->1 edge on the synchronised signal sets pend.
  - pend is sticky until interrupt entry. A further edge while pend=1 is absorbed (no counting).
- MTC0: when oper=01 and en=1, the selected register gets data_w at the edge. CAUSE writes are ignored.
- State machine:
  - IDLE -> ENTER when pend & SR.IE & id_valid & en & oper≠10 & hold=0.
  - IDLE -> RET when oper=10 & en. ERET has priority over a simultaneous entry condition; that interrupt is then taken from IDLE later, once its conditions hold again.
  - ENTER (1 cycle): jump_en=1, jump_addr=EHBR.
    - On entry to ENTER: EPC<=ret_addr, SR.IE<=0, CAUSE code<=0, pend<=0.
    - These writes override a same-cycle MTC0 to SR or EPC.
    - Next state HOLD.
  - RET (1 cycle): jump_en=1, jump_addr=EPC (value before any same-cycle MTC0); SR.IE<=1. Next state HOLD.
  - HOLD: load the counter with HOLD_CYC, decrement each enabled cycle, return to IDLE when it reaches 0. ERET arriving in HOLD is ignored, because the controller flushes it.
- jump_en and jump_addr are registered:
  - the decision is made at edge N;
  - the pulse is high for exactly the cycle between edges N and N+1;
  - jump_addr is 0 whenever jump_en=0.
- en=0 freezes state, pend and registers. jump_en must not stay high more than one cycle, so it is forced to 0 while en=0.
- Reset mid-ENTER/RET: the pulse is dropped and all state is cleared; no EPC update is retained beyond reset.
- data_r: combinational read of the stored value; there is no MTC0-to-MFC0 bypass within the same cycle.

Decomposition:
- Shared package or include: oper encodings (EXE_CP_NONE/STORE, EXE_CP0_ERET), CP0 register indices, SR/CAUSE bit positions, FSM state encodings.
- One sub-module: `int_sync`, the parameterised synchroniser plus rising-edge detector producing a one-cycle `ir_edge`.

Test Plan:
- Reset, then MTC0 EHBR=0x0000_1000 and MTC0 SR=1; MFC0 addr 25 -> data_r=0x0000_1000, and addr 12 -> data_r=1.
- With SR.IE=1, pulse ir_in while id_valid=1 and ret_addr=0x40 -> after sync latency + 1 cycle, jump_en=1 for one cycle with jump_addr=0x1000; EPC=0x40; SR=0; CAUSE[31]=0.
- ERET after entry (EPC=0x40) -> jump_en=1 for one cycle with jump_addr=0x40; SR.IE=1.
- Interrupt edge with SR.IE=0 -> no jump and CAUSE[31]=1. MTC0 SR=1 -> entry within 2 cycles with EPC=ret_addr.
- ERET and an entry condition in the same cycle -> RET is taken first (jump_addr=EPC); the interrupt is taken after HOLD_CYC=2 cycles with jump_addr=EHBR.
- Assert rst=0 during ENTER -> jump_en=0 the next cycle; SR, EPC and CAUSE read 0; a later ir_in edge with IE=0 causes no jump.
